// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: fetch FIFO feeding the decoder, issue register toward the scoreboard,
// control-flow stall and flush. Optional perf counters under DECODE_ISSUE_CTRL_PERF_EN.
// Latency: push in cycle N -> decoder head N+1 -> issue_valid_o N+2; 1 instr/cycle.
// Backpressure: fetch_ready_o low when FIFO full; issue payload held while !issue_ready_i.
module decode_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int SB_W  = 128,
    parameter int PC_W  = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_valid_i,
    output logic            fetch_ready_o,
    input  logic [PC_W-1:0] fetch_pc_i,
    input  logic [31:0]     fetch_instr_i,
    input  logic            fetch_is_comp_i,
    output logic [PC_W-1:0] dec_pc_o,
    output logic [31:0]     dec_instr_o,
    output logic            dec_is_comp_o,
    input  logic [SB_W-1:0] dec_entry_i,
    input  logic            dec_is_cf_i,
    output logic            issue_valid_o,
    input  logic            issue_ready_i,
    output logic [SB_W-1:0] issue_entry_o,
    output logic [PC_W-1:0] issue_pc_o,
    input  logic            resolve_i,
    input  logic            flush_i,
    output logic            cf_pending_o
`ifdef DECODE_ISSUE_CTRL_PERF_EN
    ,
    output logic [31:0]     perf_issued_o,
    output logic [31:0]     perf_cf_stall_o,
    output logic [31:0]     perf_full_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic            is_comp;
    } fetch_t;

    typedef enum logic {RUN, WAIT_CF} state_t;

    fetch_t        mem [DEPTH];
    fetch_t        head;
    fetch_t        wr_dat;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          fifo_empty, push, pop, slot_free;
    state_t        state, state_nxt;

    assign fifo_empty    = (count == '0);
    assign fetch_ready_o = (count != CNT_FULL);
    assign push          = fetch_valid_i & fetch_ready_o;
    assign slot_free     = ~issue_valid_o | issue_ready_i;
    assign pop           = ~fifo_empty & slot_free & (state == RUN) & ~flush_i;
    assign cf_pending_o  = (state == WAIT_CF);

    assign wr_dat = '{pc: fetch_pc_i, instr: fetch_instr_i, is_comp: fetch_is_comp_i};
    assign head   = mem[rd_ptr];

    // Decoder sees zeros when the FIFO is empty so a stale head never leaks downstream.
    assign dec_pc_o      = fifo_empty ? '0 : head.pc;
    assign dec_instr_o   = fifo_empty ? '0 : head.instr;
    assign dec_is_comp_o = fifo_empty ? 1'b0 : head.is_comp;

    always_ff @(posedge clk) begin
        if (push && !flush_i) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN:     if (pop && dec_is_cf_i) state_nxt = WAIT_CF;
                WAIT_CF: if (resolve_i) state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_valid_o <= 1'b0;
            issue_entry_o <= '0;
            issue_pc_o    <= '0;
        end else if (flush_i) begin
            issue_valid_o <= 1'b0;
        end else if (pop) begin
            issue_valid_o <= 1'b1;
            issue_entry_o <= dec_entry_i;
            issue_pc_o    <= dec_pc_o;
        end else if (issue_valid_o && issue_ready_i) begin
            issue_valid_o <= 1'b0;
        end
    end

`ifdef DECODE_ISSUE_CTRL_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    // Counters survive flush on purpose: they measure the whole run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_issued_o   <= '0;
            perf_cf_stall_o <= '0;
            perf_full_o     <= '0;
        end else begin
            perf_issued_o   <= sat_inc(perf_issued_o, pop);
            perf_cf_stall_o <= sat_inc(perf_cf_stall_o, (state == WAIT_CF) & ~fifo_empty);
            perf_full_o     <= sat_inc(perf_full_o, fetch_valid_i & ~fetch_ready_o);
        end
    end
`endif

endmodule
